// File: rtl/cpu_pkg.sv
// Shared CPU encodings: transfer sizes, read/write
// polarity and the memory controller state type.
package cpu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } ram_state_t;

endpackage

// File: rtl/data_ram_controller_if.sv
// MFA/MFC request/response bundle between the
// control unit (master) and the data RAM (slave).
interface data_ram_controller_if #(
  parameter int ADDR_W = 9
);

  logic              ramMFA;
  logic              ramRW;
  logic [1:0]        ramDataSize;
  logic [ADDR_W-1:0] ramAddress;
  logic [31:0]       dataIn;
  logic [31:0]       dataOut;
  logic              ramMFC;
  logic              alignErr;

  modport master (
    output ramMFA,
    output ramRW,
    output ramDataSize,
    output ramAddress,
    output dataIn,
    input  dataOut,
    input  ramMFC,
    input  alignErr
  );

  modport slave (
    input  ramMFA,
    input  ramRW,
    input  ramDataSize,
    input  ramAddress,
    input  dataIn,
    output dataOut,
    output ramMFC,
    output alignErr
  );

endinterface

// File: rtl/data_ram_controller_lane_steer.sv
// Big-endian lane steering: byte enables and lane
// data for writes, right-justified read data.
module ram_lane_steer
  import cpu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] lane,
  output logic [31:0] rdata,
  output logic        misalign
);

  // Lane 0 is the lowest address and sits in
  // rword[31:24]; reserved size behaves as word.
  always_comb begin
    be       = 4'b0000;
    lane     = 32'h0;
    rdata    = 32'h0;
    misalign = 1'b0;
    unique case (size)
      SIZE_BYTE: begin
        be   = 4'b1000 >> addr;
        lane = {4{wdata[7:0]}};
        unique case (addr)
          2'd0: rdata = {24'h0, rword[31:24]};
          2'd1: rdata = {24'h0, rword[23:16]};
          2'd2: rdata = {24'h0, rword[15:8]};
          default:
            rdata = {24'h0, rword[7:0]};
        endcase
      end
      SIZE_HALF: begin
        misalign = addr[0];
        lane     = {2{wdata[15:0]}};
        if (!addr[0])
          be = addr[1] ? 4'b0011 : 4'b1100;
        rdata = addr[1] ?
          {16'h0, rword[15:0]} :
          {16'h0, rword[31:16]};
      end
      default: begin
        misalign = |addr;
        be       = misalign ? 4'b0000 : 4'b1111;
        lane     = wdata;
        rdata    = rword;
      end
    endcase
  end

endmodule

// File: rtl/data_ram_controller.sv
// Byte-addressed big-endian data RAM with a fixed
// latency MFA/MFC handshake and alignment checking.
module data_ram_controller
  import cpu_pkg::*;
#(
  parameter int    ADDR_W    = 9,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input logic Clk,
  input logic reset,
  data_ram_controller_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] CNT_INIT =
    4'(LATENCY - 1);

  logic [7:0] mem [DEPTH];

  ram_state_t        state;
  ram_state_t        state_n;
  logic [3:0]        cnt;
  logic [3:0]        cnt_n;
  logic              accept;
  logic              finish;

  logic              rw_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [31:0]       dout_q;
  logic              err_q;

  logic [ADDR_W-1:0] a0;
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [ADDR_W-1:0] a3;
  logic [31:0]       rword;
  logic [3:0]        be;
  logic [31:0]       lane;
  logic [31:0]       rdata;
  logic              misalign;
  logic              we;

  // The containing aligned word; aligned
  // accesses never leave it, so no wrap.
  assign a0 = {addr_q[ADDR_W-1:2], 2'b00};
  assign a1 = {addr_q[ADDR_W-1:2], 2'b01};
  assign a2 = {addr_q[ADDR_W-1:2], 2'b10};
  assign a3 = {addr_q[ADDR_W-1:2], 2'b11};

  assign rword = {mem[a0], mem[a1],
                  mem[a2], mem[a3]};

  ram_lane_steer u_steer (
    .size     (size_q),
    .addr     (addr_q[1:0]),
    .wdata    (wdata_q),
    .rword    (rword),
    .be       (be),
    .lane     (lane),
    .rdata    (rdata),
    .misalign (misalign)
  );

  // Next state: dropping MFA in BUSY aborts.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.ramMFA) begin
          state_n = BUSY;
          cnt_n   = CNT_INIT;
          accept  = 1'b1;
        end
      end
      BUSY: begin
        if (!bus.ramMFA) begin
          state_n = IDLE;
        end else if (cnt == 4'd0) begin
          state_n = DONE;
          finish  = 1'b1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      DONE: begin
        if (!bus.ramMFA)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and latency counter.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Capture the request when it is accepted.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      rw_q    <= RW_READ;
      size_q  <= SIZE_BYTE;
      addr_q  <= '0;
      wdata_q <= 32'h0;
    end else if (accept) begin
      rw_q    <= bus.ramRW;
      size_q  <= bus.ramDataSize;
      addr_q  <= bus.ramAddress;
      wdata_q <= bus.dataIn;
    end
  end

  // Read data and error flag for the response.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      dout_q <= 32'h0;
      err_q  <= 1'b0;
    end else if (finish) begin
      err_q <= misalign;
      if (rw_q == RW_READ && !misalign)
        dout_q <= rdata;
    end else if (state_n == IDLE) begin
      err_q <= 1'b0;
    end
  end

  assign we = finish &&
              rw_q == RW_WRITE &&
              !misalign;

  // Byte array write port.
  always_ff @(posedge Clk) begin
    if (we) begin
      if (be[3]) mem[a0] <= lane[31:24];
      if (be[2]) mem[a1] <= lane[23:16];
      if (be[1]) mem[a2] <= lane[15:8];
      if (be[0]) mem[a3] <= lane[7:0];
    end
  end

  assign bus.ramMFC   = (state == DONE);
  assign bus.dataOut  = dout_q;
  assign bus.alignErr = err_q;

endmodule
